// File: rtl/uart_tx_arbiter.sv
// Two-source AXI-Stream packet arbiter feeding one UART transmitter, with round-robin
// contention and a single output register stage. Define TX_ARB_TIMEOUT_EN to enable the stall timeout.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [1:0]            grant,
    output logic                  timeout_error
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    last_served_reg, last_served_next;
    logic [DATA_WIDTH-1:0]   tdata_reg;
    logic                    tvalid_reg;
    logic                    tlast_reg;

    logic                    out_free;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    timeout_hit;

    // Output stage can take a new beat when empty or draining this cycle.
    assign out_free = !tvalid_reg || m_axis_tready;

    always_comb begin
        state_next       = state_reg;
        last_served_next = last_served_reg;
        s0_axis_tready   = 1'b0;
        s1_axis_tready   = 1'b0;
        accept           = 1'b0;
        sel_data         = s0_axis_tdata;
        sel_last         = s0_axis_tlast;
        grant            = 2'b00;
        unique case (state_reg)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid)
                    state_next = last_served_reg ? GRANT0 : GRANT1;
                else if (s0_axis_tvalid)
                    state_next = GRANT0;
                else if (s1_axis_tvalid)
                    state_next = GRANT1;
            end
            GRANT0: begin
                grant          = 2'b01;
                s0_axis_tready = out_free;
                accept         = s0_axis_tvalid && out_free;
                if ((accept && s0_axis_tlast) || timeout_hit) begin
                    state_next       = IDLE;
                    last_served_next = 1'b0;
                end
            end
            GRANT1: begin
                grant          = 2'b10;
                s1_axis_tready = out_free;
                accept         = s1_axis_tvalid && out_free;
                sel_data       = s1_axis_tdata;
                sel_last       = s1_axis_tlast;
                if ((accept && s1_axis_tlast) || timeout_hit) begin
                    state_next       = IDLE;
                    last_served_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_reg       <= IDLE;
            last_served_reg <= 1'b1;
            tdata_reg       <= '0;
            tvalid_reg      <= 1'b0;
            tlast_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_served_reg <= last_served_next;
            if (accept) begin
                tdata_reg  <= sel_data;
                tlast_reg  <= sel_last;
                tvalid_reg <= 1'b1;
            end else if (m_axis_tready) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;

`ifdef TX_ARB_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_reg, stall_cnt_next;
    logic        timeout_error_reg;
    logic        granted_valid;

    // A stall is only a cycle where the owner has nothing to offer; backpressure does not count.
    always_comb begin
        granted_valid  = 1'b0;
        if (state_reg == GRANT0)
            granted_valid = s0_axis_tvalid;
        else if (state_reg == GRANT1)
            granted_valid = s1_axis_tvalid;
        timeout_hit    = (state_reg != IDLE) && !granted_valid && (stall_cnt_reg == STALL_LIMIT);
        stall_cnt_next = stall_cnt_reg;
        if (state_reg == IDLE || accept || state_next != state_reg)
            stall_cnt_next = '0;
        else if (!granted_valid)
            stall_cnt_next = stall_cnt_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            stall_cnt_reg     <= '0;
            timeout_error_reg <= 1'b0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            if (timeout_hit)
                timeout_error_reg <= 1'b1;
        end
    end

    assign timeout_error = timeout_error_reg;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter: packets, contention, round-robin,
// backpressure, mid-packet reset, plus hand-written stall/timeout sequence.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic [7:0] s0_tdata = '0, s1_tdata = '0;
    logic       s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
    logic       s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast;
    logic       m_tready = 1'b1;
    logic [1:0] grant;
    logic       timeout_error;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .arstn          (arstn),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .grant          (grant),
        .timeout_error  (timeout_error)
    );

    typedef struct {
        bit       rst;
        bit       s0v; logic [7:0] s0d; bit s0l;
        bit       s1v; logic [7:0] s1d; bit s1l;
        bit       mr;
        bit       e_r0; bit e_r1;
        bit [1:0] e_g;
        bit       e_v; logic [7:0] e_d; bit e_l;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit s0v, logic [7:0] s0d, bit s0l,
                                bit s1v, logic [7:0] s1d, bit s1l, bit mr,
                                bit e_r0, bit e_r1, bit [1:0] e_g,
                                bit e_v, logic [7:0] e_d, bit e_l);
        vec_t v;
        v.rst = rst; v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
        v.s1v = s1v; v.s1d = s1d; v.s1l = s1l; v.mr = mr;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_g = e_g;
        v.e_v = e_v; v.e_d = e_d; v.e_l = e_l;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit s0v, logic [7:0] s0d, bit s0l, bit s1v, logic [7:0] s1d, bit s1l, bit mr);
        s0_tvalid = s0v; s0_tdata = s0d; s0_tlast = s0l;
        s1_tvalid = s1v; s1_tdata = s1d; s1_tlast = s1l;
        m_tready  = mr;
    endtask

    initial begin
        // rst s0v s0d s0l s1v s1d s1l mr | rdy0 rdy1 grant valid data last
        // single packet 11,22,33(last) from s0
        add(0, 1, 8'h11, 0, 0, 8'h00, 0, 1,  0, 0, 2'b01, 0, 8'h00, 0);
        add(0, 1, 8'h11, 0, 0, 8'h00, 0, 1,  1, 0, 2'b01, 1, 8'h11, 0);
        add(0, 1, 8'h22, 0, 0, 8'h00, 0, 1,  1, 0, 2'b01, 1, 8'h22, 0);
        add(0, 1, 8'h33, 1, 0, 8'h00, 0, 1,  1, 0, 2'b00, 1, 8'h33, 1);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 2'b00, 0, 8'h00, 0);
        // contention straight after reset: s0 wins, packet not interleaved
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 2'b00, 0, 8'h00, 0);
        add(0, 1, 8'hA1, 0, 1, 8'hB1, 1, 1,  0, 0, 2'b01, 0, 8'h00, 0);
        add(0, 1, 8'hA1, 0, 1, 8'hB1, 1, 1,  1, 0, 2'b01, 1, 8'hA1, 0);
        add(0, 1, 8'hA2, 1, 1, 8'hB1, 1, 1,  1, 0, 2'b00, 1, 8'hA2, 1);
        add(0, 0, 8'h00, 0, 1, 8'hB1, 1, 1,  0, 0, 2'b10, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 1, 8'hB1, 1, 1,  0, 1, 2'b00, 1, 8'hB1, 1);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 2'b00, 0, 8'h00, 0);
        // round-robin with both sources always offering one-byte packets
        for (int k = 0; k < 2; k++) begin
            add(0, 1, 8'hA0, 1, 1, 8'hB0, 1, 1,  0, 0, 2'b01, 0, 8'h00, 0);
            add(0, 1, 8'hA0, 1, 1, 8'hB0, 1, 1,  1, 0, 2'b00, 1, 8'hA0, 1);
            add(0, 1, 8'hA0, 1, 1, 8'hB0, 1, 1,  0, 0, 2'b10, 0, 8'h00, 0);
            add(0, 1, 8'hA0, 1, 1, 8'hB0, 1, 1,  0, 1, 2'b00, 1, 8'hB0, 1);
        end
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 2'b00, 0, 8'h00, 0);
        // backpressure: 0x5A held five cycles, then 0x5B(last) follows
        add(0, 1, 8'h5A, 0, 0, 8'h00, 0, 1,  0, 0, 2'b01, 0, 8'h00, 0);
        add(0, 1, 8'h5A, 0, 0, 8'h00, 0, 1,  1, 0, 2'b01, 1, 8'h5A, 0);
        for (int k = 0; k < 5; k++)
            add(0, 1, 8'h5B, 1, 0, 8'h00, 0, 0,  0, 0, 2'b01, 1, 8'h5A, 0);
        add(0, 1, 8'h5B, 1, 0, 8'h00, 0, 1,  1, 0, 2'b00, 1, 8'h5B, 1);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 2'b00, 0, 8'h00, 0);
        // reset one cycle after the first byte of a packet
        add(0, 1, 8'hC1, 0, 0, 8'h00, 0, 1,  0, 0, 2'b01, 0, 8'h00, 0);
        add(0, 1, 8'hC1, 0, 0, 8'h00, 0, 1,  1, 0, 2'b01, 1, 8'hC1, 0);
        add(1, 1, 8'hC2, 0, 0, 8'h00, 0, 1,  1, 0, 2'b00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 2'b00, 0, 8'h00, 0);

        arstn = 1'b0;
        repeat (2) tick();
        check("reset grant", grant, 2'b00);
        check("reset m_tvalid", m_tvalid, 1'b0);
        check("reset m_tdata", m_tdata, 8'h00);
        check("reset m_tlast", m_tlast, 1'b0);
        check("reset s0_tready", s0_tready, 1'b0);
        check("reset s1_tready", s1_tready, 1'b0);
        check("reset timeout_error", timeout_error, 1'b0);
        arstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            arstn = !v.rst;
            drive(v.s0v, v.s0d, v.s0l, v.s1v, v.s1d, v.s1l, v.mr);
            #1;
            check($sformatf("row%0d s0_tready", i), s0_tready, v.e_r0);
            check($sformatf("row%0d s1_tready", i), s1_tready, v.e_r1);
            tick();
            check($sformatf("row%0d grant", i), grant, v.e_g);
            check($sformatf("row%0d m_tvalid", i), m_tvalid, v.e_v);
            check($sformatf("row%0d timeout_error", i), timeout_error, 1'b0);
            if (v.e_v || v.rst) begin
                check($sformatf("row%0d m_tdata", i), m_tdata, v.e_d);
                check($sformatf("row%0d m_tlast", i), m_tlast, v.e_l);
            end
            $display("row %0d: grant=%b valid=%b data=%h last=%b", i, grant, m_tvalid, m_tdata, m_tlast);
            arstn = 1'b1;
        end

        // Stall: s0 sends 0x01 without tlast, then goes quiet while s1 waits.
        drive(1, 8'h01, 0, 1, 8'hE1, 1, 1);
        tick();
        check("stall grant s0", grant, 2'b01);
        tick();
        check("stall first byte", m_tdata, 8'h01);
        check("stall first valid", m_tvalid, 1'b1);
        drive(0, 8'h00, 0, 1, 8'hE1, 1, 1);
        repeat (3) tick();
        check("stall 3 cycles grant", grant, 2'b01);
        check("stall 3 cycles timeout", timeout_error, 1'b0);
        check("stall s1_tready", s1_tready, 1'b0);
        tick();
`ifdef TX_ARB_TIMEOUT_EN
        check("timeout grant released", grant, 2'b00);
        check("timeout flag set", timeout_error, 1'b1);
        check("timeout no tlast", m_tlast, 1'b0);
        tick();
        check("timeout grant s1", grant, 2'b10);
        tick();
        check("after timeout data", m_tdata, 8'hE1);
        check("after timeout valid", m_tvalid, 1'b1);
        check("after timeout last", m_tlast, 1'b1);
        check("timeout flag sticky", timeout_error, 1'b1);
`else
        repeat (4) tick();
        check("hold grant indefinitely", grant, 2'b01);
        check("no timeout flag", timeout_error, 1'b0);
        check("s1 still blocked", m_tdata, 8'h01);
`endif
        $display("stall sequence: grant=%b timeout_error=%b data=%h", grant, timeout_error, m_tdata);

        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        check("final reset grant", grant, 2'b00);
        check("final reset timeout", timeout_error, 1'b0);
        check("final reset valid", m_tvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width of all stream data ports.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535 (range 1..65535): the number of consecutive mid-packet stall cycles before a forced release.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  system clock.
- arstn  input  1  reset, active-low, synchronous to clk.
- s0_axis_tdata  input  DATA_WIDTH  source 0 (processor output) byte.
- s0_axis_tvalid / s0_axis_tlast  input  1 each.
- s0_axis_tready  output  1.
- s1_axis_tdata  input  DATA_WIDTH  source 1 (status/ack) byte.
- s1_axis_tvalid / s1_axis_tlast  input  1 each.
- s1_axis_tready  output  1.
- m_axis_tdata  output  DATA_WIDTH  byte to the UART transmitter.
- m_axis_tvalid / m_axis_tlast  output  1 each.
- m_axis_tready  input  1.
- grant  output  2  one-hot current owner: bit0 = s0, bit1 = s1, 00 = idle.
- timeout_error  output  1  sticky stall-timeout flag.
REQ-004 SHALL use one clock (clk); reset arstn SHALL be synchronous and active-low.

Function
REQ-005 SHALL implement the FSM states IDLE, GRANT0 and GRANT1; grant SHALL be 01 in GRANT0, 10 in GRANT1 and 00 in IDLE.
REQ-006 SHALL, in IDLE with exactly one sN_axis_tvalid high, move to GRANTN on the next edge.
REQ-007 SHALL, in IDLE with both sources valid, grant the source that is not last_served (round-robin).
REQ-008 SHALL update the 1-bit last_served register when each packet completes.
REQ-009 SHALL accept no beats while in IDLE: both tready outputs low.
REQ-010 SHALL drive the granted source's tready as (!m_axis_tvalid || m_axis_tready); the non-granted tready SHALL be 0.
REQ-011 SHALL hold the output in a single register stage: an accepted beat appears on m_axis one cycle after acceptance, with tdata and tlast copied unchanged.
REQ-012 SHALL keep m_axis_tvalid and m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-013 SHALL clear m_axis_tvalid after a transfer unless a new beat is accepted in the same cycle, so back-to-back beats sustain 1 beat per cycle.
REQ-014 SHALL never interleave packets: an accepted beat with tlast=1 in GRANTN moves the FSM to IDLE and sets last_served=N.
REQ-015 SHALL allow the next grant to be decided from IDLE while the final byte is still held in the output register.
REQ-016 SHALL ignore activity on the non-granted source; that source's data is held, not dropped.

Reset
REQ-017 SHALL, on any clk edge with arstn=0, set: state IDLE, grant 00, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, both tready 0, last_served 1 (s0 wins first contention), stall counter 0, timeout_error 0.
REQ-018 SHALL discard any partial packet and the output register contents when reset is asserted mid-packet.

Configuration
REQ-019 SHALL, with TX_ARB_TIMEOUT_EN defined:
- count consecutive cycles in GRANTN with sN_axis_tvalid=0;
- clear the count on any accepted beat or on leaving GRANTN;
- when the count reaches TIMEOUT_CYCLES, go to IDLE, set last_served=N and set timeout_error=1 (sticky until reset);
- emit no synthetic tlast.
REQ-020 SHALL, without TX_ARB_TIMEOUT_EN, omit the counter, tie timeout_error to 0 and hold a grant indefinitely; the port list is identical in both builds.

Verification
REQ-021 Single packet: s0 sends 0x11, 0x22, 0x33(last) with m_axis_tready=1 -> m_axis carries 11, 22, 33 on consecutive cycles, tlast only on 0x33; grant 01 then 00.
REQ-022 Contention after reset: both sources valid, s0 packet A1, A2(last), s1 packet B1(last) -> output A1, A2, B1; no B1 between A bytes.
REQ-023 Round-robin: both sources continuously present 1-byte packets 0xA0 / 0xB0 -> output alternates A0, B0, A0, B0.
REQ-024 Backpressure: m_axis_tready=0 for 5 cycles mid-packet with 0x5A held -> m_axis_tdata stays 0x5A; s0_axis_tready=0; no byte lost or duplicated.
REQ-025 Timeout (macro defined, TIMEOUT_CYCLES=4): s0 sends 0x01 without tlast then drops tvalid, s1 valid -> after 4 stall cycles timeout_error=1, grant moves to s1; s1 bytes follow.
REQ-026 Reset mid-packet: arstn low one cycle after s0 first byte -> next cycle m_axis_tvalid=0, grant=00, timeout_error=0.
